// File: rtl/cache_dma_pkg.sv
// Shared types and geometry helpers for the cache DMA responder.
package cache_dma_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_RD_BURST,
        S_RD_DRAIN,
        S_WR_BURST,
        S_RESP_RD,
        S_RESP_WR
    } state_e;

    function automatic int calc_wpl(input int block_bits, input int word_bits);
        return block_bits / word_bits;
    endfunction

    function automatic int calc_ofs(input int block_bits);
        return $clog2(block_bits / 8);
    endfunction

    function automatic logic [63:0] line_align(input logic [63:0] addr, input int ofs);
        return addr & ~((64'd1 << ofs) - 64'd1);
    endfunction

endpackage

// File: rtl/dma_word_ram.sv
// Word-wide single-port synchronous RAM: one access per cycle, read data one cycle later.
module dma_word_ram
    import cache_dma_pkg::*;
#(
    parameter int WORD_BITS = 32,
    parameter int MEM_WORDS = 16384,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    logic [WORD_BITS-1:0] mem_q [MEM_WORDS];
    logic [WORD_BITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_dma_responder.sv
// Memory-side DMA responder: serial word bursts for line fills and evictions.
// Build option DMA_MEM_INIT_EN: after reset, fill RAM with word w := w before serving.
module cache_dma_responder
    import cache_dma_pkg::*;
#(
    parameter int BLOCK_BITS = 512,
    parameter int WORD_BITS  = 32,
    parameter int ADDR_BITS  = 32,
    parameter int MEM_WORDS  = 16384,
    parameter int LATENCY    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_BITS-1:0]  addr_out_request_DMA_i,
    input  logic                  request_DMA_i,
    input  logic [BLOCK_BITS-1:0] data_out_evict_DMA_i,
    input  logic [ADDR_BITS-1:0]  addr_out_evict_DMA_i,
    input  logic                  evict_DMA_i,
    output logic [BLOCK_BITS-1:0] data_in_request_DMA_o,
    output logic [ADDR_BITS-1:0]  addr_in_request_DMA_o,
    output logic                  request_valid_DMA_o,
    output logic                  evict_DMA_o,
    output logic                  busy_o
);

    localparam int WPL = calc_wpl(BLOCK_BITS, WORD_BITS);
    localparam int OFS = calc_ofs(BLOCK_BITS);
    localparam int AW  = $clog2(MEM_WORDS);
    localparam int BSH = $clog2(WORD_BITS / 8);
    localparam int WIX = $clog2(WPL);
    localparam int CW  = $clog2(WPL + LATENCY + 1);
`ifdef DMA_MEM_INIT_EN
    localparam state_e RST_STATE = S_INIT;
`else
    localparam state_e RST_STATE = S_IDLE;
`endif

    state_e                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic                          is_wr_q;
    logic [ADDR_BITS-1:0]          base_q, addr_o_q;
    logic [WPL-1:0][WORD_BITS-1:0] line_q, fill_line_d;
    logic [BLOCK_BITS-1:0]         data_o_q;
    logic                          rd_pend_q;
    logic [WIX-1:0]                rd_idx_q;
    logic                          rvalid_q, evict_q;
`ifdef DMA_MEM_INIT_EN
    logic [AW-1:0]                 init_q;
`endif

    logic                 ram_en, ram_we;
    logic [AW-1:0]        ram_addr, base_word;
    logic [WORD_BITS-1:0] ram_wdata, ram_rdata;
    logic [WIX-1:0]       wi;

    assign wi        = cnt_q[WIX-1:0];
    assign base_word = AW'(base_q >> BSH);

    // Read data trails its request by a cycle; merge it into the line being assembled.
    always_comb begin
        fill_line_d           = line_q;
        fill_line_d[rd_idx_q] = ram_rdata;
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = base_word + AW'(cnt_q);
        ram_wdata = line_q[wi];
        case (state_q)
            S_RD_BURST: ram_en = 1'b1;
            // Gating on reset keeps the word in flight out of RAM when a burst is abandoned.
            S_WR_BURST: begin ram_en = 1'b1; ram_we = !rst_i; end
`ifdef DMA_MEM_INIT_EN
            S_INIT: begin
                ram_en    = 1'b1;
                ram_we    = !rst_i;
                ram_addr  = init_q;
                ram_wdata = WORD_BITS'(init_q);
            end
`endif
            default: ;
        endcase
    end

    dma_word_ram #(.WORD_BITS(WORD_BITS), .MEM_WORDS(MEM_WORDS)) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            base_q    <= '0;
            addr_o_q  <= '0;
            line_q    <= '0;
            data_o_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            rvalid_q  <= 1'b0;
            evict_q   <= 1'b0;
`ifdef DMA_MEM_INIT_EN
            init_q    <= '0;
`endif
        end else begin
            rvalid_q  <= 1'b0;
            evict_q   <= 1'b0;
            rd_pend_q <= (state_q == S_RD_BURST);
            rd_idx_q  <= wi;
            if (rd_pend_q) line_q <= fill_line_d;
            case (state_q)
`ifdef DMA_MEM_INIT_EN
                S_INIT: begin
                    init_q <= init_q + AW'(1);
                    if (init_q == AW'(MEM_WORDS - 1)) state_q <= S_IDLE;
                end
`endif
                S_IDLE: begin
                    cnt_q <= '0;
                    // Eviction wins so a write-back always lands before any refill.
                    if (evict_DMA_i) begin
                        base_q  <= ADDR_BITS'(line_align(64'(addr_out_evict_DMA_i), OFS));
                        line_q  <= data_out_evict_DMA_i;
                        is_wr_q <= 1'b1;
                        state_q <= (LATENCY == 0) ? S_WR_BURST : S_WAIT;
                    end else if (request_DMA_i) begin
                        base_q  <= ADDR_BITS'(line_align(64'(addr_out_request_DMA_i), OFS));
                        is_wr_q <= 1'b0;
                        state_q <= (LATENCY == 0) ? S_RD_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CW'(LATENCY - 1)) begin
                        cnt_q   <= '0;
                        state_q <= is_wr_q ? S_WR_BURST : S_RD_BURST;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RD_BURST: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WPL - 1)) state_q <= S_RD_DRAIN;
                end
                S_RD_DRAIN: begin
                    data_o_q <= fill_line_d;
                    addr_o_q <= base_q;
                    rvalid_q <= 1'b1;
                    state_q  <= S_RESP_RD;
                end
                S_WR_BURST: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WPL - 1)) begin
                        evict_q <= 1'b1;
                        state_q <= S_RESP_WR;
                    end
                end
                S_RESP_RD, S_RESP_WR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_in_request_DMA_o = data_o_q;
    assign addr_in_request_DMA_o = addr_o_q;
    assign request_valid_DMA_o   = rvalid_q;
    assign evict_DMA_o           = evict_q;
    assign busy_o                = (state_q != S_IDLE);

endmodule
